cla_serial_add_ctrl: RTL and testbench
======================================

CLA_SERIAL_ADD_CTRL -- requirements
Module: cla_serial_add_ctrl

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 16, operand/result width; legal values are multiples of 4 and at least 4; NIB = WIDTH/4.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit, operation request, sampled only in IDLE.
REQ-005 The block SHALL have port a, input, WIDTH bits, operand A, captured on start acceptance.
REQ-006 The block SHALL have port b, input, WIDTH bits, operand B, captured on start acceptance.
REQ-007 The block SHALL have port cin, input, 1 bit, carry-in for add, captured on start acceptance.
REQ-008 The block SHALL have port sub, input, 1 bit, 1 = subtract (A - B), captured on start acceptance.
REQ-009 The block SHALL have port busy, output, 1 bit, high while in RUN.
REQ-010 The block SHALL have port done, output, 1 bit, one-cycle pulse, high while in DONE.
REQ-011 The block SHALL have port sum, output, WIDTH bits, registered result.
REQ-012 The block SHALL have port cout, output, 1 bit, carry out of bit WIDTH-1.
REQ-013 The block SHALL have port ovf, output, 1 bit, two's-complement overflow.

Function
REQ-014 The block SHALL implement a three-state FSM: IDLE, RUN and DONE.
REQ-015 IDLE with start=1: at that edge, the block SHALL capture a, b (inverted if sub=1), an initial carry (cin if sub=0, 1 if sub=1, cin ignored) and sub; it SHALL clear the nibble index to 0 and go to RUN.
REQ-016 IDLE with start=0: the block SHALL stay in IDLE.
REQ-017 Each RUN edge SHALL process nibble[index] through one internal 4-bit carry-lookahead slice.
  - The slice SHALL compute per bit g=a&b and p=a^b, with c[i]=g[i]|(p[i]&c[i-1]) and s[i]=p[i]^c[i-1].
  - The result nibble SHALL be written into an internal accumulator.
  - The slice carry-out SHALL be stored in a carry register used as the next nibble's carry-in.
  - The index SHALL increment.
REQ-018 On the RUN edge processing nibble NIB-1, the block SHALL go to DONE and load sum, cout and ovf from the accumulator and slice.
  - ovf SHALL equal the carry into bit WIDTH-1 XOR the carry out of bit WIDTH-1.
REQ-019 The block SHALL spend exactly one cycle in DONE and then go to IDLE unconditionally.
REQ-020 Latency SHALL be fixed: with start accepted at edge k, busy=1 from edge k to edge k+NIB, and done=1 from edge k+NIB to k+NIB+1; minimum accept-to-accept period is NIB+2 cycles.
REQ-021 The block SHALL ignore start while in RUN or DONE, with no queuing.
REQ-022 Changes on a, b, cin or sub after acceptance SHALL NOT affect the result in progress.
REQ-023 sum, cout and ovf SHALL change only on entry to DONE or on reset, and SHALL hold their values through IDLE and the following RUN.
REQ-024 Arithmetic SHALL be modulo 2^WIDTH; in subtract mode, cout=1 means no borrow (A >= B unsigned).
REQ-025 The block SHALL support WIDTH=4 (NIB=1): a single RUN cycle, period 3 cycles.
REQ-026 The nibble index SHALL be at least 1 bit wide and SHALL never exceed NIB-1.

Reset
REQ-027 When rst=1 at an edge, the block SHALL go to IDLE with busy=0, done=0, sum=0, cout=0, ovf=0, carry register and index cleared; rst SHALL take priority over start and every FSM transition.
REQ-028 Reset in RUN or DONE SHALL abort the operation; the block SHALL produce no done pulse for it and SHALL accept start from the first edge with rst=0.

Verification (WIDTH=16 unless noted)
REQ-029 Scenario: a=FFFF, b=0001, cin=0, sub=0 -> sum=0000, cout=1, ovf=0; done=1 exactly 4 cycles after the accepting edge; busy high 4 cycles.
REQ-030 Scenario: a=7FFF, b=0001, cin=0, sub=0 -> sum=8000, cout=0, ovf=1; carry ripples across all nibble boundaries.
REQ-031 Scenario: sub=1, a=0005, b=0007, cin=1 -> sum=FFFE, cout=0, ovf=0 (cin ignored); then sub=1, a=8000, b=0001 -> sum=7FFF, cout=1, ovf=1.
REQ-032 Scenario: a=1234, b=4321, cin=1, sub=0, with a and b driven to random values during RUN -> sum=5556, cout=0, ovf=0.
REQ-033 Scenario: start held at 1 continuously -> accepts exactly every 6 cycles; done is a 1-cycle pulse; sum is stable between done pulses.
REQ-034 Scenario: rst=1 for one cycle during the 2nd RUN cycle -> next cycle all outputs 0, no done pulse follows; a new start then completes normally. Repeat with WIDTH=4: a=F, b=1 -> sum=0, cout=1, period 3.

Source files
------------

// File: rtl/cla_serial_add_ctrl.sv
// Nibble-serial adder/subtractor: one 4-bit carry-lookahead slice is reused
// across NIB cycles, with a small IDLE/RUN/DONE controller around it.
module cla_serial_add_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NIB = WIDTH / 4;
  // Index is kept at least one bit wide so WIDTH=4 still has a legal vector.
  localparam int IW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIB - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] a_reg, b_reg, acc, acc_next;
  logic             carry;
  logic [IW-1:0]    idx;
  logic [IW+1:0]    base;
  logic [3:0]       na, nb, g, p, s;
  logic             c_into_msb, c_out;
  logic             last;

  assign base = {idx, 2'b00};
  assign na   = a_reg[base +: 4];
  assign nb   = b_reg[base +: 4];
  assign last = (idx == LAST);

  // 4-bit carry-lookahead slice working on the currently selected nibble.
  always_comb begin
    logic cc;
    g          = na & nb;
    p          = na ^ nb;
    s          = '0;
    c_into_msb = 1'b0;
    cc         = carry;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) c_into_msb = cc;
      s[i] = p[i] ^ cc;
      cc   = g[i] | (p[i] & cc);
    end
    c_out = cc;
  end

  // Accumulator with the freshly computed nibble merged into its slot.
  always_comb begin
    acc_next = acc;
    acc_next[base +: 4] = s;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic and status outputs decoded from the current state.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: if (start) state_next = RUN;
      RUN: begin
        busy = 1'b1;
        if (last) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: operand capture on accept, one nibble per RUN cycle, result
  // registers loaded only on the last nibble so they hold between operations.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg <= '0;
      b_reg <= '0;
      acc   <= '0;
      carry <= 1'b0;
      idx   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_reg <= a;
            b_reg <= sub ? ~b : b;
            carry <= sub ? 1'b1 : cin;
            acc   <= '0;
            idx   <= '0;
          end
        end
        RUN: begin
          acc   <= acc_next;
          carry <= c_out;
          if (last) begin
            idx  <= '0;
            sum  <= acc_next;
            cout <= c_out;
            ovf  <= c_out ^ c_into_msb;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cla_serial_add_ctrl.sv
// Scoreboard bench: stimulus pushes expected results, monitors pop on done.
module tb_cla_serial_add_ctrl;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  logic        start16, cin16, sub16, busy16, done16, cout16, ovf16;
  logic [15:0] a16, b16, sum16;
  logic        start4, cin4, sub4, busy4, done4, cout4, ovf4;
  logic [3:0]  a4, b4, sum4;

  cla_serial_add_ctrl #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .cin(cin16),
    .sub(sub16), .busy(busy16), .done(done16), .sum(sum16), .cout(cout16),
    .ovf(ovf16)
  );

  cla_serial_add_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .sub(sub4), .busy(busy4), .done(done4), .sum(sum4), .cout(cout4),
    .ovf(ovf4)
  );

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } exp16_t;

  typedef struct packed {
    logic [3:0] sum;
    logic       cout;
    logic       ovf;
  } exp4_t;

  exp16_t q16[$];
  exp4_t  q4[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Monitor for the 16-bit instance.
  always @(negedge clk) begin
    if (done16 === 1'b1) begin
      if (q16.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL unexpected done16: got done, expected none");
      end else begin
        exp16_t e;
        e = q16.pop_front();
        checkOutput("sum16", 32'(sum16), 32'(e.sum));
        checkOutput("cout16", 32'(cout16), 32'(e.cout));
        checkOutput("ovf16", 32'(ovf16), 32'(e.ovf));
      end
    end
  end

  // Monitor for the 4-bit instance.
  always @(negedge clk) begin
    if (done4 === 1'b1) begin
      if (q4.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL unexpected done4: got done, expected none");
      end else begin
        exp4_t e;
        e = q4.pop_front();
        checkOutput("sum4", 32'(sum4), 32'(e.sum));
        checkOutput("cout4", 32'(cout4), 32'(e.cout));
        checkOutput("ovf4", 32'(ovf4), 32'(e.ovf));
      end
    end
  end

  // One 16-bit operation; called at a negedge with the DUT idle.
  task automatic applyStimulus(input logic [15:0] av, input logic [15:0] bv,
                               input logic ci, input logic sb,
                               input logic [15:0] es, input logic ec,
                               input logic eo, input bit scramble,
                               input string tag);
    exp16_t e;
    int     busy_cnt;
    bit     seen;
    e.sum = es; e.cout = ec; e.ovf = eo;
    a16 = av; b16 = bv; cin16 = ci; sub16 = sb; start16 = 1'b1;
    q16.push_back(e);
    @(posedge clk);
    @(negedge clk);
    start16  = 1'b0;
    busy_cnt = 0;
    seen     = 0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      if (i > 1) @(negedge clk);
      if (scramble) begin
        a16   = 16'($urandom);
        b16   = 16'($urandom);
        cin16 = 1'($urandom);
        sub16 = 1'($urandom);
      end
      if (busy16) busy_cnt++;
      if (done16) begin
        seen = 1;
        checkOutput({tag, " latency"}, 32'(i), 32'd5);
      end
    end
    if (!seen) checkOutput({tag, " done timeout"}, 32'd0, 32'd1);
    checkOutput({tag, " busy cycles"}, 32'(busy_cnt), 32'd4);
    @(negedge clk);
    checkOutput({tag, " hold in idle"}, 32'(sum16), 32'(es));
  endtask

  // One 4-bit operation; called at a negedge with the DUT idle.
  task automatic applyStimulus4(input logic [3:0] av, input logic [3:0] bv,
                                input logic ci, input logic sb,
                                input logic [3:0] es, input logic ec,
                                input logic eo, input string tag);
    exp4_t e;
    int    busy_cnt;
    bit    seen;
    e.sum = es; e.cout = ec; e.ovf = eo;
    a4 = av; b4 = bv; cin4 = ci; sub4 = sb; start4 = 1'b1;
    q4.push_back(e);
    @(posedge clk);
    @(negedge clk);
    start4   = 1'b0;
    busy_cnt = 0;
    seen     = 0;
    for (int i = 1; i <= 10 && !seen; i++) begin
      if (i > 1) @(negedge clk);
      if (busy4) busy_cnt++;
      if (done4) begin
        seen = 1;
        checkOutput({tag, " latency"}, 32'(i), 32'd2);
      end
    end
    if (!seen) checkOutput({tag, " done timeout"}, 32'd0, 32'd1);
    checkOutput({tag, " busy cycles"}, 32'(busy_cnt), 32'd1);
    @(negedge clk);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    exp16_t e16;
    exp4_t  e4;
    int     done_count, last_done, dcount;
    bit     prev_done;

    rst = 1'b1;
    start16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0; sub16 = 1'b0;
    start4  = 1'b0; a4  = '0; b4  = '0; cin4  = 1'b0; sub4  = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    checkOutput("reset busy16", 32'(busy16), 32'd0);
    checkOutput("reset done16", 32'(done16), 32'd0);
    checkOutput("reset sum16", 32'(sum16), 32'd0);
    checkOutput("reset cout16", 32'(cout16), 32'd0);
    checkOutput("reset ovf16", 32'(ovf16), 32'd0);
    checkOutput("reset busy4", 32'(busy4), 32'd0);
    checkOutput("reset sum4", 32'(sum4), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] directed 16-bit vectors");
    applyStimulus(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 0, "ffff+1");
    applyStimulus(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 0, "7fff+1");
    applyStimulus(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 0, "5-7");
    applyStimulus(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 0, "8000-1");
    applyStimulus(16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0, 1, "scrambled");

    $display("[TB] start held high");
    e16.sum = 16'h0123; e16.cout = 1'b0; e16.ovf = 1'b0;
    repeat (3) q16.push_back(e16);
    a16 = 16'h0100; b16 = 16'h0023; cin16 = 1'b0; sub16 = 1'b0; start16 = 1'b1;
    done_count = 0; last_done = 0; prev_done = 0;
    for (int cyc = 0; cyc < 40 && done_count < 3; cyc++) begin
      @(negedge clk);
      if (done16) begin
        checkOutput("done one-cycle", 32'(prev_done), 32'd0);
        if (done_count > 0) checkOutput("held period", 32'(cyc - last_done), 32'd6);
        last_done = cyc;
        done_count++;
        if (done_count == 3) start16 = 1'b0;
      end else if (done_count > 0) begin
        checkOutput("held sum stable", 32'(sum16), 32'h0123);
      end
      prev_done = done16;
    end
    checkOutput("held done count", 32'(done_count), 32'd3);
    @(negedge clk);
    @(negedge clk);
    checkOutput("no accept after release", 32'(busy16), 32'd0);

    $display("[TB] reset during second RUN cycle");
    a16 = 16'h0001; b16 = 16'h0001; start16 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start16 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort busy", 32'(busy16), 32'd0);
    checkOutput("abort done", 32'(done16), 32'd0);
    checkOutput("abort sum", 32'(sum16), 32'd0);
    checkOutput("abort cout", 32'(cout16), 32'd0);
    checkOutput("abort ovf", 32'(ovf16), 32'd0);
    dcount = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done16) dcount++;
    end
    checkOutput("no done after abort", 32'(dcount), 32'd0);
    applyStimulus(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 0, "after abort");

    $display("[TB] 4-bit instance");
    applyStimulus4(4'h7, 4'h1, 1'b0, 1'b0, 4'h8, 1'b0, 1'b1, "w4 7+1");
    applyStimulus4(4'h3, 4'h5, 1'b0, 1'b1, 4'hE, 1'b0, 1'b0, "w4 3-5");
    e4.sum = 4'h0; e4.cout = 1'b1; e4.ovf = 1'b0;
    repeat (3) q4.push_back(e4);
    a4 = 4'hF; b4 = 4'h1; cin4 = 1'b0; sub4 = 1'b0; start4 = 1'b1;
    done_count = 0; last_done = 0; prev_done = 0;
    for (int cyc = 0; cyc < 20 && done_count < 3; cyc++) begin
      @(negedge clk);
      if (done4) begin
        checkOutput("w4 done one-cycle", 32'(prev_done), 32'd0);
        if (done_count > 0) checkOutput("w4 held period", 32'(cyc - last_done), 32'd3);
        last_done = cyc;
        done_count++;
        if (done_count == 3) start4 = 1'b0;
      end
      prev_done = done4;
    end
    checkOutput("w4 held done count", 32'(done_count), 32'd3);
    repeat (3) @(negedge clk);

    checkOutput("queue16 drained", 32'(q16.size()), 32'd0);
    checkOutput("queue4 drained", 32'(q4.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
